// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and
// registers the returned word into the IF/ID register with redirect, stall, halt and fault handling.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 1024,
    parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic        id_valid,
    output logic        halted,
    output logic        fault,
    output logic [31:0] fetch_count
);

    // 33-bit limit so a full 4 GiB memory does not overflow the compare
    localparam logic [32:0] PC_LIMIT = 33'(IMEM_WORDS) * 33'd4;

    logic [31:0] pc_q, pc_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_pc_plus4_q, id_pc_plus4_d;
    logic        id_valid_q, id_valid_d;
    logic        halted_q, halted_d;
    logic        fault_q, fault_d;
    logic [31:0] fetch_count_q, fetch_count_d;
    logic        pc_out_of_range;

    assign pc_out_of_range = {1'b0, pc_q} >= PC_LIMIT;

    always_comb begin
        pc_d          = pc_q;
        id_instr_d    = id_instr_q;
        id_pc_d       = id_pc_q;
        id_pc_plus4_d = id_pc_plus4_q;
        id_valid_d    = id_valid_q;
        halted_d      = halted_q;
        fault_d       = fault_q;
        fetch_count_d = fetch_count_q;

        if (redirect_valid) begin
            pc_d       = {redirect_pc[31:2], 2'b00};
            id_valid_d = 1'b0;
            halted_d   = 1'b0;
            fault_d    = 1'b0;
        end else if (halted_q || fault_q) begin
            // Frozen: drain a bubble unless decode is stalled on the last word
            if (!stall) id_valid_d = 1'b0;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (pc_out_of_range) begin
            fault_d    = 1'b1;
            id_valid_d = 1'b0;
        end else begin
            id_instr_d    = imem_instr;
            id_pc_d       = pc_q;
            id_pc_plus4_d = pc_q + 32'd4;
            id_valid_d    = 1'b1;
            fetch_count_d = fetch_count_q + 32'd1;
            if (imem_instr == HALT_WORD) halted_d = 1'b1;
            else                         pc_d     = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            id_instr_q    <= 32'd0;
            id_pc_q       <= 32'd0;
            id_pc_plus4_q <= 32'd0;
            id_valid_q    <= 1'b0;
            halted_q      <= 1'b0;
            fault_q       <= 1'b0;
            fetch_count_q <= 32'd0;
        end else begin
            pc_q          <= pc_d;
            id_instr_q    <= id_instr_d;
            id_pc_q       <= id_pc_d;
            id_pc_plus4_q <= id_pc_plus4_d;
            id_valid_q    <= id_valid_d;
            halted_q      <= halted_d;
            fault_q       <= fault_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign imem_addr   = pc_q;
    assign id_instr    = id_instr_q;
    assign id_pc       = id_pc_q;
    assign id_pc_plus4 = id_pc_plus4_q;
    assign id_valid    = id_valid_q;
    assign halted      = halted_q;
    assign fault       = fault_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a full-size instance plus a 4-word instance for fault checks,
// both fed from the same small memory image.
`timescale 1ns/1ps
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] mem [0:15];

    logic [31:0] imem_addr, imem_instr, id_instr, id_pc, id_pc_plus4, fetch_count;
    logic        id_valid, halted, fault;
    logic [31:0] imem_addr_s, imem_instr_s, id_instr_s, id_pc_s, id_pc_plus4_s, fetch_count_s;
    logic        id_valid_s, halted_s, fault_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        imem_instr   = (imem_addr   < 32'd64) ? mem[imem_addr[5:2]]   : 32'hDEAD_BEEF;
        imem_instr_s = (imem_addr_s < 32'd64) ? mem[imem_addr_s[5:2]] : 32'hDEAD_BEEF;
    end

    fetch_unit #(.IMEM_WORDS(1024)) dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_instr(imem_instr),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_instr(id_instr), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4), .id_valid(id_valid),
        .halted(halted), .fault(fault), .fetch_count(fetch_count)
    );

    fetch_unit #(.IMEM_WORDS(4)) dut_s (
        .clk(clk), .reset(reset), .imem_addr(imem_addr_s), .imem_instr(imem_instr_s),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_instr(id_instr_s), .id_pc(id_pc_s), .id_pc_plus4(id_pc_plus4_s), .id_valid(id_valid_s),
        .halted(halted_s), .fault(fault_s), .fetch_count(fetch_count_s)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_mem();
        for (int i = 0; i < 16; i++) mem[i] = 32'h11 * (i + 1);
    endtask

    task automatic do_reset();
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({imem_addr, id_instr, id_pc, id_pc_plus4, fetch_count, id_valid, halted, fault} !== {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 3'b000}) begin
            errors++;
            $display("FAIL reset_state addr=%h instr=%h pc=%h p4=%h cnt=%0d v/h/f=%b%b%b required all zero",
                     imem_addr, id_instr, id_pc, id_pc_plus4, fetch_count, id_valid, halted, fault);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_i, exp_pc;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            exp_i  = 32'h11 * (i + 1);
            exp_pc = 32'(4 * i);
            checks++;
            if ({id_instr, id_pc, id_pc_plus4, fetch_count, id_valid, imem_addr} !== {exp_i, exp_pc, exp_pc + 32'd4, 32'(i + 1), 1'b1, exp_pc + 32'd4}) begin
                errors++;
                $display("FAIL seq_fetch%0d instr=%h pc=%h p4=%h cnt=%0d v=%b addr=%h required instr=%h pc=%h",
                         i, id_instr, id_pc, id_pc_plus4, fetch_count, id_valid, imem_addr, exp_i, exp_pc);
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        step(); step();
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if ({id_instr, id_pc, imem_addr, fetch_count, id_valid} !== {32'h22, 32'h4, 32'h8, 32'd2, 1'b1}) begin
                errors++;
                $display("FAIL stall_hold%0d instr=%h pc=%h addr=%h cnt=%0d v=%b required 22/4/8/2/1",
                         i, id_instr, id_pc, imem_addr, fetch_count, id_valid);
            end
        end
        stall = 1'b0;
        step();
        checks++;
        if ({id_instr, id_pc, fetch_count, id_valid} !== {32'h33, 32'h8, 32'd3, 1'b1}) begin
            errors++;
            $display("FAIL stall_resume instr=%h pc=%h cnt=%0d v=%b required 33/8/3/1", id_instr, id_pc, fetch_count, id_valid);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        step();
        redirect_valid = 1'b1; redirect_pc = 32'h13; stall = 1'b1;
        step();
        checks++;
        if ({imem_addr, id_valid, fetch_count} !== {32'h10, 1'b0, 32'd1}) begin
            errors++;
            $display("FAIL redirect_edge addr=%h v=%b cnt=%0d required 10/0/1", imem_addr, id_valid, fetch_count);
        end
        redirect_valid = 1'b0; stall = 1'b0;
        step();
        checks++;
        if ({id_pc, id_instr, id_pc_plus4, id_valid, fetch_count} !== {32'h10, 32'h55, 32'h14, 1'b1, 32'd2}) begin
            errors++;
            $display("FAIL redirect_target pc=%h instr=%h p4=%h v=%b cnt=%0d required 10/55/14/1/2",
                     id_pc, id_instr, id_pc_plus4, id_valid, fetch_count);
        end
    endtask

    task automatic test_halt();
        mem[2] = 32'hFFFF_FFFF;
        do_reset();
        step(); step(); step();
        checks++;
        if ({id_instr, id_valid, halted, imem_addr, fetch_count} !== {32'hFFFF_FFFF, 1'b1, 1'b1, 32'h8, 32'd3}) begin
            errors++;
            $display("FAIL halt_capture instr=%h v=%b h=%b addr=%h cnt=%0d required ffffffff/1/1/8/3",
                     id_instr, id_valid, halted, imem_addr, fetch_count);
        end
        stall = 1'b1;
        step();
        checks++;
        if ({id_valid, halted, imem_addr, fetch_count} !== {1'b1, 1'b1, 32'h8, 32'd3}) begin
            errors++;
            $display("FAIL halt_stall v=%b h=%b addr=%h cnt=%0d required 1/1/8/3", id_valid, halted, imem_addr, fetch_count);
        end
        stall = 1'b0;
        step();
        checks++;
        if ({id_valid, halted, imem_addr, fetch_count} !== {1'b0, 1'b1, 32'h8, 32'd3}) begin
            errors++;
            $display("FAIL halt_bubble v=%b h=%b addr=%h cnt=%0d required 0/1/8/3", id_valid, halted, imem_addr, fetch_count);
        end
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        step();
        checks++;
        if ({halted, imem_addr, id_valid} !== {1'b0, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL halt_redirect h=%b addr=%h v=%b required 0/0/0", halted, imem_addr, id_valid);
        end
        redirect_valid = 1'b0;
        step();
        checks++;
        if ({id_instr, id_pc, id_valid, fetch_count} !== {32'h11, 32'h0, 1'b1, 32'd4}) begin
            errors++;
            $display("FAIL halt_refetch instr=%h pc=%h v=%b cnt=%0d required 11/0/1/4", id_instr, id_pc, id_valid, fetch_count);
        end
        mem[2] = 32'h33;
    endtask

    task automatic test_fault();
        do_reset();
        for (int i = 0; i < 4; i++) step();
        checks++;
        if ({id_pc_s, id_instr_s, fetch_count_s, fault_s, imem_addr_s} !== {32'hC, 32'h44, 32'd4, 1'b0, 32'h10}) begin
            errors++;
            $display("FAIL fault_last_word pc=%h instr=%h cnt=%0d f=%b addr=%h required c/44/4/0/10",
                     id_pc_s, id_instr_s, fetch_count_s, fault_s, imem_addr_s);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if ({fault_s, id_valid_s, imem_addr_s, fetch_count_s} !== {1'b1, 1'b0, 32'h10, 32'd4}) begin
                errors++;
                $display("FAIL fault_set%0d f=%b v=%b addr=%h cnt=%0d required 1/0/10/4",
                         i, fault_s, id_valid_s, imem_addr_s, fetch_count_s);
            end
        end
        do_reset();
        checks++;
        if ({fault_s, imem_addr_s, fetch_count_s} !== {1'b0, 32'h0, 32'd0}) begin
            errors++;
            $display("FAIL fault_clear f=%b addr=%h cnt=%0d required 0/0/0", fault_s, imem_addr_s, fetch_count_s);
        end
    endtask

    task automatic test_reset_priority();
        mem[2] = 32'hFFFF_FFFF;
        do_reset();
        step(); step(); step();
        redirect_valid = 1'b1; redirect_pc = 32'h20; stall = 1'b1; reset = 1'b1;
        step();
        checks++;
        if ({imem_addr, id_instr, id_pc, id_pc_plus4, fetch_count, id_valid, halted, fault} !== {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 3'b000}) begin
            errors++;
            $display("FAIL reset_priority addr=%h instr=%h pc=%h p4=%h cnt=%0d v/h/f=%b%b%b required all zero",
                     imem_addr, id_instr, id_pc, id_pc_plus4, fetch_count, id_valid, halted, fault);
        end
        reset = 1'b0; redirect_valid = 1'b0; stall = 1'b0;
        mem[2] = 32'h33;
    endtask

    initial begin
        load_mem();
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_halt();
        test_fault();
        test_reset_priority();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage sitting directly upstream of the instruction memory: owns the program counter, drives the word address into the memory and registers the returned word into the IF/ID pipeline register. Handles pipeline stall, branch/jump redirect with flush, halt-word detection and out-of-range fetch faults. Feeds the decode stage with instruction, PC and PC+4.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset (byte address, word aligned)
- IMEM_WORDS, 1024, instruction memory depth in 32-bit words; valid byte range 0 .. 4*IMEM_WORDS-4
- HALT_WORD, 32'hFFFF_FFFF, encoding that stops sequential fetch
- clk  input  1  single clock, all state updates on rising edge
- reset  input  1  synchronous, active-high
- imem_addr  output  32  byte address to instruction memory, equals pc (combinational)
- imem_instr  input  32  instruction word returned by memory for imem_addr
- stall  input  1  hold PC and IF/ID register
- redirect_valid  input  1  branch/jump taken; load redirect_pc and flush IF/ID
- redirect_pc  input  32  redirect target; bits [1:0] ignored (forced 00)
- id_instr  output  32  registered instruction to decode
- id_pc  output  32  byte address of id_instr
- id_pc_plus4  output  32  id_pc + 4, mod 2^32
- id_valid  output  1  IF/ID contents are a real instruction
- halted  output  1  HALT_WORD fetched; sequential fetch frozen
- fault  output  1  fetch attempted at pc >= 4*IMEM_WORDS
- fetch_count  output  32  number of instructions captured into IF/ID

## Operation
- Internal state: pc, IF/ID register (id_instr, id_pc, id_pc_plus4, id_valid), halted, fault, fetch_count.
- Per-edge priority: reset > redirect_valid > (halted or fault) > stall > normal fetch.
- reset: pc<=RESET_PC; id_instr, id_pc, id_pc_plus4, fetch_count <= 0; id_valid, halted, fault <= 0.
- redirect_valid=1: pc<={redirect_pc[31:2],2'b00}; id_valid<=0 (other IF/ID fields don't-care, held); halted<=0; fault<=0. Overrides stall, halted, fault. Counter unchanged.
- halted=1 or fault=1 (no redirect): pc holds; if stall=1 IF/ID holds, else id_valid<=0. Counter unchanged.
- stall=1 (no redirect, not halted/faulted): pc and whole IF/ID hold; counter unchanged.
- Normal fetch, pc >= 4*IMEM_WORDS: fault<=1, id_valid<=0, pc holds.
- Normal fetch, pc in range: id_instr<=imem_instr, id_pc<=pc, id_pc_plus4<=pc+4, id_valid<=1, fetch_count<=fetch_count+1 (wraps mod 2^32). If imem_instr==HALT_WORD: halted<=1, pc holds; else pc<=pc+4.
- The halt word itself is delivered to decode with id_valid=1; bubbles follow.
- Halt is speculative: a later redirect (older branch resolving) clears halted and resumes fetch at the target.
- imem_addr is never registered separately; it tracks pc so memory sees the new address immediately after each edge.

## Timing
- Fetch latency: word at address A appears on id_instr one edge after pc==A.
- First capture: first rising edge with reset=0; id_pc=RESET_PC.
- Instruction memory has 1000 ps output delay after an address change; clock period ≥ 2 ns in simulation so imem_instr is settled before sampling edge.
- Redirect takes effect on the edge it is sampled; target instruction in IF/ID one edge later; exactly one bubble (id_valid=0) between.
- halted/fault assert in the cycle after the triggering edge; deassert the cycle after a redirect edge or reset edge.
- Reset asserted mid-stall, mid-halt or with redirect_valid=1: reset wins, all state to reset values.
- pc+4 at 32'hFFFF_FFFC wraps to 0 (only reachable when IMEM_WORDS covers it; otherwise fault fires first).

## Test plan
- Reset, memory words 0..3 = 0x11,0x22,0x33,0x44 -> id_instr 0x11,0x22,0x33 on successive edges, id_pc 0,4,8, id_pc_plus4 4,8,12, fetch_count 1,2,3.
- stall=1 for 2 cycles while id_pc=4 -> id_instr=0x22, id_pc=4, imem_addr=8 held; fetch_count unchanged; resumes with 0x33.
- redirect_valid=1, redirect_pc=0x0000_0013 together with stall=1 -> next cycle pc=0x10, id_valid=0; following cycle id_pc=0x10.
- Word at 0x8 = 0xFFFF_FFFF -> id_instr=0xFFFF_FFFF with id_valid=1, halted=1, pc stays 0x8, subsequent id_valid=0; redirect to 0x0 clears halted and refetches 0x11.
- IMEM_WORDS=4, sequential run past 0xC -> at pc=0x10 fault=1, id_valid=0, pc holds 0x10, fetch_count=4; reset clears fault and pc=0.
- reset asserted while halted=1 and redirect_valid=1 -> all outputs at reset values next cycle, pc=RESET_PC.
